seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Receive-side decoder for the stopwatch's multiplexed 7-segment bus. It samples the `seg`/`an` pins that `display` drives and waits for each scan dwell to settle. It then decodes the segment pattern back into a digit value and assembles the four digits into frames. It sits beside `display` as a self-check and readback block, and its outputs mirror the `min_l`/`min_r`/`sec_l`/`sec_r` values that feed `display`.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical samples of `{an,seg}` required before a capture; legal range 2..255.
- `TIMEOUT_CYCLES`, default 1048576: cycles without a capture before `scan_lost` asserts; only used with `SEGCAP_TIMEOUT_EN`.
- `clk` in 1: system clock, the same clock that drives `display`.
- `btn_reset` in 1: asynchronous, active-high reset.
- `seg` in 7: segment pins, active-low; `seg[0]`=a … `seg[6]`=g.
- `an` in 4: anode pins, active-low; `an[3]`=min_l, `an[2]`=min_r, `an[1]`=sec_l, `an[0]`=sec_r.
- `min_l`, `min_r`, `sec_l`, `sec_r` out 5 each: decoded digits.
- `frame_valid` out 1: one-cycle pulse when all four digits have been captured since the last frame.
- `pattern_err` out 1: one-cycle pulse on an undecodable capture.
- `scan_lost` out 1: level; asserted when no scan activity is seen.

## Operation
- Input register: `{an,seg}` is registered once. All logic below uses the registered sample.
- Stability counter: 8-bit.
  - Reset to 0 when the sample differs from the previous sample.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- FSM states:
  - SETTLE → CAPTURE when count = `STABLE_CYCLES`-1 and the sample is unchanged.
  - CAPTURE lasts exactly 1 cycle, then → HOLD.
  - HOLD → SETTLE on any sample change.
  - Any change during SETTLE stays in SETTLE with the count cleared.
  - Result: exactly one capture per stable dwell.
- Capture action, by anode pattern:
  - `an`=1111: no digit selected. Capture is ignored; no error.
  - Exactly one `an` bit low: decode `seg` into the selected digit register and set that digit's bit in a 4-bit seen mask.
  - Two or more `an` bits low: `pattern_err` pulse; no register changes.
- Decode table (`seg[6:0]`):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111→31 (blank, legal; used by adjust-mode blink)
  - Any other pattern → 30, plus a `pattern_err` pulse. The digit is still written and its mask bit still set.
- Frame assembly:
  - When a capture makes the mask 1111, `frame_valid` pulses at the same edge the completing digit register updates, and the mask clears to 0000.
  - Recapturing a digit already in the mask overwrites its value and does not advance the frame.

## Timing
- Reset values:
  - `min_l`/`min_r`/`sec_l`/`sec_r` = 31.
  - `frame_valid` = 0, `pattern_err` = 0, `scan_lost` = 0.
  - Mask = 0000, count = 0, FSM = SETTLE.
- Latency: a pin pattern first present before edge N updates its digit output at edge N+`STABLE_CYCLES`. `pattern_err` and `frame_valid` assert at that same edge.
- Dwells shorter than `STABLE_CYCLES` cycles are never captured; they are treated as glitches.
- Reset mid-dwell or mid-frame: all state returns to reset values immediately. The first frame after reset needs four fresh captures.
- `display` dwell at the 380 Hz scan is far longer than 255 cycles, so each dwell yields exactly one capture.

## Configuration
- `SEGCAP_TIMEOUT_EN` defined:
  - A cycle counter clears on every capture and increments otherwise, saturating.
  - On reaching `TIMEOUT_CYCLES`, `scan_lost` sets and the mask clears.
  - `scan_lost` clears at the next capture edge. It is independent of `frame_valid`.
- `SEGCAP_TIMEOUT_EN` undefined: no counter is built, `scan_lost` is tied 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `TIMEOUT_CYCLES`=64.
- Reset: assert `btn_reset` asynchronously mid-dwell → all four digits read 31 and all flags read 0 within the same cycle.
- Normal scan: scan an 3..0 with digits 5,6,7,8, dwell 10 cycles each → outputs 5,6,7,8; one `frame_valid` pulse on the sec_r capture; capture edge is 4 cycles after each dwell starts.
- Glitch rejection: 3-cycle dwell of an=1110 showing "1" between valid dwells → no change to `sec_r`; frame count unchanged.
- Bad pattern and multiple anodes:
  - seg=1010101 on an=0111 → `min_l`=30 and one `pattern_err` pulse.
  - an=0011 held stable → one `pattern_err` pulse and no digit change.
- Blank and partial frame: blank (1111111) on an=1011 → `min_r`=31 with no error. Repeating `min_l` twice then completing the rest → exactly one `frame_valid` pulse.
- Timeout (`SEGCAP_TIMEOUT_EN`): hold an=1111 for 64 cycles → `scan_lost`=1 and mask clears. The next valid capture returns `scan_lost` to 0. With the macro undefined, `scan_lost` stays 0.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: decodes the multiplexed 7-segment scan back into four digits and frames them.
// Optional scan-loss watchdog built when SEGCAP_TIMEOUT_EN is defined.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       scan_lost
);
  typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD} state_t;
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] SAT    = 8'(STABLE_CYCLES);
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("seg_scan_capture: parameter out of range");
  end
  state_t      state, state_nx;
  logic [10:0] samp;
  logic [7:0]  cnt;
  logic [3:0]  mask, mask_nx, sel;
  logic [4:0]  val;
  logic        changed, do_cap, dig_cap, one_sel, multi, bad, timeout_hit;
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: dec = 5'd0;
      7'b1111001: dec = 5'd1;
      7'b0100100: dec = 5'd2;
      7'b0110000: dec = 5'd3;
      7'b0011001: dec = 5'd4;
      7'b0010010: dec = 5'd5;
      7'b0000010: dec = 5'd6;
      7'b1111000: dec = 5'd7;
      7'b0000000: dec = 5'd8;
      7'b0010000: dec = 5'd9;
      7'b1111111: dec = 5'd31;
      default:    dec = 5'd30;
    endcase
  endfunction
  // The incoming pins are compared against the held sample so that a dwell first
  // registered at edge N is captured exactly STABLE_CYCLES edges later.
  assign changed = {an, seg} != samp;
  assign sel     = ~samp[10:7];
  assign one_sel = $onehot(sel);
  assign multi   = !one_sel && sel != 4'h0;
  assign val     = dec(samp[6:0]);
  assign bad     = val == 5'd30;
  assign do_cap  = state == SETTLE && !changed && cnt == CAP_AT;
  assign dig_cap = do_cap && one_sel;
  assign mask_nx = mask | sel;
  always_comb begin
    state_nx = state;
    state_nx = changed ? SETTLE :
               do_cap ? CAPTURE :
               state == CAPTURE ? HOLD : state;
  end
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      state <= SETTLE;
      samp  <= '1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      samp  <= {an, seg};
      cnt   <= changed ? 8'd0 : (cnt == SAT ? cnt : cnt + 8'd1);
    end
  end
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      min_l       <= 5'd31;
      min_r       <= 5'd31;
      sec_l       <= 5'd31;
      sec_r       <= 5'd31;
      mask        <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_valid <= dig_cap && &mask_nx;
      pattern_err <= do_cap && (multi || (one_sel && bad));
      if (dig_cap) begin
        if (sel[3]) min_l <= val;
        if (sel[2]) min_r <= val;
        if (sel[1]) sec_l <= val;
        if (sel[0]) sec_r <= val;
        mask <= &mask_nx ? 4'h0 : mask_nx;
      end else if (timeout_hit) begin
        mask <= '0;
      end
    end
  end
`ifdef SEGCAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  assign timeout_hit = !dig_cap && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      tcnt      <= '0;
      scan_lost <= 1'b0;
    end else if (dig_cap) begin
      tcnt      <= '0;
      scan_lost <= 1'b0;
    end else begin
      if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
      if (timeout_hit) scan_lost <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign scan_lost   = 1'b0;
`endif
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: scoreboard bench; stimulus queues expected capture events, a monitor checks them.
module tb_seg_scan_capture;
  localparam int S = 4;
  logic       clk = 1'b0;
  logic       btn_reset = 1'b1;
  logic [6:0] seg = 7'h7f;
  logic [3:0] an = 4'hf;
  logic [4:0] min_l, min_r, sec_l, sec_r;
  logic       frame_valid, pattern_err, scan_lost;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  typedef struct {logic [19:0] d; logic fv; logic pe; int c;} ev_t;
  ev_t        q[$];
  logic [19:0] last = '1;
  seg_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .btn_reset(btn_reset), .seg(seg), .an(an),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .frame_valid(frame_valid), .pattern_err(pattern_err), .scan_lost(scan_lost)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [19:0] cur;
    ev_t e;
    cur = {min_l, min_r, sec_l, sec_r};
    if (!btn_reset && (cur != last || frame_valid || pattern_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got d=%h fv=%b pe=%b", cyc, cur, frame_valid, pattern_err);
      end else begin
        e = q.pop_front();
        if (cur != e.d || frame_valid != e.fv || pattern_err != e.pe || cyc != e.c) begin
          errors++;
          $display("FAIL capture_event got d=%h fv=%b pe=%b cyc=%0d want d=%h fv=%b pe=%b cyc=%0d",
                   cur, frame_valid, pattern_err, cyc, e.d, e.fv, e.pe, e.c);
        end
      end
    end
    last = cur;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len, input bit ev,
                       input logic [4:0] ml, mr, sl, sr, input bit fv, input bit pe);
    @(posedge clk);
    #1;
    an  = a;
    seg = s;
    if (ev) q.push_back('{d: {ml, mr, sl, sr}, fv: fv, pe: pe, c: cyc + 1 + S});
    repeat (len - 1) @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #3;
    check("reset_min_l", 32'(min_l), 31);
    check("reset_sec_r", 32'(sec_r), 31);
    btn_reset = 1'b0;
    dwell(4'b0111, 7'b0010010, 10, 1,  5, 31, 31, 31, 0, 0);
    dwell(4'b1011, 7'b0000010, 10, 1,  5,  6, 31, 31, 0, 0);
    dwell(4'b1101, 7'b1111000, 10, 1,  5,  6,  7, 31, 0, 0);
    dwell(4'b1110, 7'b0000000, 10, 1,  5,  6,  7,  8, 1, 0);
    dwell(4'b1110, 7'b1111001,  3, 0,  0,  0,  0,  0, 0, 0);
    dwell(4'b1111, 7'b1111111, 10, 0,  0,  0,  0,  0, 0, 0);
    dwell(4'b0111, 7'b1010101, 10, 1, 30,  6,  7,  8, 0, 1);
    dwell(4'b0011, 7'b0010010, 10, 1, 30,  6,  7,  8, 0, 1);
    dwell(4'b1011, 7'b1111111, 10, 1, 30, 31,  7,  8, 0, 0);
    dwell(4'b0111, 7'b1111001, 10, 1,  1, 31,  7,  8, 0, 0);
    dwell(4'b0111, 7'b0100100, 10, 1,  2, 31,  7,  8, 0, 0);
    dwell(4'b1011, 7'b0010000, 10, 1,  2,  9,  7,  8, 0, 0);
    dwell(4'b1101, 7'b0110000, 10, 1,  2,  9,  3,  8, 0, 0);
    dwell(4'b1110, 7'b0011001, 10, 1,  2,  9,  3,  4, 1, 0);
    dwell(4'b1111, 7'b1111111, 70, 0,  0,  0,  0,  0, 0, 0);
    #2;
`ifdef SEGCAP_TIMEOUT_EN
    check("scan_lost_timeout", 32'(scan_lost), 1);
`else
    check("scan_lost_tied", 32'(scan_lost), 0);
`endif
    dwell(4'b0111, 7'b1000000, 10, 1,  0,  9,  3,  4, 0, 0);
    check("scan_lost_after_capture", 32'(scan_lost), 0);
    dwell(4'b1011, 7'b1111001, 10, 1,  0,  1,  3,  4, 0, 0);
    dwell(4'b1101, 7'b0100100, 10, 1,  0,  1,  2,  4, 0, 0);
    check("queue_drained_pre_reset", 32'(q.size()), 0);
    @(posedge clk);
    #1;
    an  = 4'b1110;
    seg = 7'b0010010;
    @(posedge clk);
    #2;
    btn_reset = 1'b1;
    #1;
    check("midreset_min_l", 32'(min_l), 31);
    check("midreset_min_r", 32'(min_r), 31);
    check("midreset_sec_l", 32'(sec_l), 31);
    check("midreset_sec_r", 32'(sec_r), 31);
    check("midreset_flags", {29'd0, frame_valid, pattern_err, scan_lost}, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    btn_reset = 1'b0;
    dwell(4'b1110, 7'b1111001, 10, 1, 31, 31, 31,  1, 0, 0);
    repeat (5) @(posedge clk);
    #2;
    check("queue_drained_end", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
